// File: rtl/rgb_pwm_sequencer_pkg.sv
// Shared colour constants and helpers for the RGB PWM sequencer.
package rgb_pwm_sequencer_pkg;

  localparam int unsigned NUM_COLORS = 3;
  localparam int unsigned COLOR_R    = 2;
  localparam int unsigned COLOR_G    = 1;
  localparam int unsigned COLOR_B    = 0;

  // One-hot colour select of the reset palette: red, green, blue repeating.
  function automatic logic [NUM_COLORS-1:0] default_color_sel(input int unsigned idx);
    logic [NUM_COLORS-1:0] sel;
    sel = '0;
    case (idx % 3)
      0:       sel[COLOR_R] = 1'b1;
      1:       sel[COLOR_G] = 1'b1;
      default: sel[COLOR_B] = 1'b1;
    endcase
    return sel;
  endfunction

  // Move a duty one LSB toward its target, never past it.
  function automatic int unsigned duty_toward(input int unsigned cur, input int unsigned tgt);
    if (cur < tgt) return cur + 1;
    if (cur > tgt) return cur - 1;
    return cur;
  endfunction

endpackage

// File: rtl/rgb_pwm_sequencer_channel.sv
// One RGB LED: three duty registers updated on frame boundaries and
// registered PWM comparators against the shared frame counter.
module rgb_pwm_sequencer_channel
  import rgb_pwm_sequencer_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_frame_start,
  input  logic                           i_mode_fade,
  input  logic [PWM_BITS-1:0]            i_pwm_cnt,
  input  logic [NUM_COLORS*PWM_BITS-1:0] i_target,
  output logic [NUM_COLORS-1:0]          o_rgb
);

  logic [PWM_BITS-1:0]   r_duty [NUM_COLORS];
  logic [NUM_COLORS-1:0] r_rgb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_COLORS; c++) r_duty[c] <= '0;
      r_rgb <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_COLORS; c++) begin
        // Comparator uses the duty in force before any load on this edge.
        r_rgb[c] <= (i_pwm_cnt < r_duty[c]);
        if (i_frame_start) begin
          if (i_mode_fade)
            r_duty[c] <= PWM_BITS'(duty_toward(32'(r_duty[c]),
                                               32'(i_target[c*PWM_BITS +: PWM_BITS])));
          else
            r_duty[c] <= i_target[c*PWM_BITS +: PWM_BITS];
        end
      end
    end
  end

  assign o_rgb = r_rgb;

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// RGB LED colour sequencer: PWM timebase, dwell/step counter and writable
// palette feeding one PWM channel per LED.
module rgb_pwm_sequencer
  import rgb_pwm_sequencer_pkg::*;
#(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned PWM_DIV     = 4,
  parameter int unsigned STEP_CYCLES = 100000000,
  parameter int unsigned NUM_STEPS   = 3,
  parameter int unsigned NUM_LEDS    = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_enable,
  input  logic                           i_mode_fade,
  input  logic                           i_wr_en,
  input  logic [$clog2(NUM_STEPS)-1:0]   i_wr_addr,
  input  logic [3*PWM_BITS-1:0]          i_wr_data,
  output logic [$clog2(NUM_STEPS)-1:0]   o_step_idx,
  output logic                           o_step_pulse,
  output logic [3*NUM_LEDS-1:0]          o_rgb_led
);

  localparam int unsigned IDX_W   = $clog2(NUM_STEPS);
  localparam int unsigned PRE_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int unsigned DWELL_W = $clog2(STEP_CYCLES);
  localparam int unsigned DATA_W  = NUM_COLORS * PWM_BITS;

  logic [PRE_W-1:0]    r_pre;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [DWELL_W-1:0]  r_dwell;
  logic [IDX_W-1:0]    r_step_idx;
  logic                r_step_pulse;
  logic [DATA_W-1:0]   r_palette [NUM_STEPS];

  logic w_tick;
  logic w_frame_start;
  logic w_dwell_tc;

  function automatic logic [DATA_W-1:0] default_entry(input int unsigned idx);
    logic [NUM_COLORS-1:0] sel;
    logic [DATA_W-1:0]     entry;
    sel = default_color_sel(idx);
    for (int unsigned c = 0; c < NUM_COLORS; c++)
      entry[c*PWM_BITS +: PWM_BITS] = {PWM_BITS{sel[c]}};
    return entry;
  endfunction

  assign w_tick        = (r_pre == PRE_W'(PWM_DIV - 1));
  assign w_frame_start = w_tick & (&r_pwm_cnt);
  assign w_dwell_tc    = (r_dwell == DWELL_W'(STEP_CYCLES - 1));

  // PWM timebase: prescaler plus free-running frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre     <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
      if (w_tick) r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
    end
  end

  // Dwell counter and step index; both freeze while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwell      <= '0;
      r_step_idx   <= '0;
      r_step_pulse <= 1'b0;
    end else begin
      r_step_pulse <= i_enable & w_dwell_tc;
      if (i_enable) begin
        if (w_dwell_tc) begin
          r_dwell    <= '0;
          r_step_idx <= (r_step_idx == IDX_W'(NUM_STEPS - 1)) ? '0 : r_step_idx + IDX_W'(1);
        end else begin
          r_dwell <= r_dwell + DWELL_W'(1);
        end
      end
    end
  end

  // Palette; out-of-range writes are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_STEPS; i++) r_palette[i] <= default_entry(i);
    end else if (i_wr_en && (32'(i_wr_addr) < NUM_STEPS)) begin
      r_palette[i_wr_addr] <= i_wr_data;
    end
  end

  for (genvar k = 0; k < NUM_LEDS; k++) begin : g_led
    logic [IDX_W-1:0] w_tgt_idx;
    assign w_tgt_idx = IDX_W'((32'(r_step_idx) + 32'(k)) % NUM_STEPS);

    rgb_pwm_sequencer_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_channel (
      .clk           (clk),
      .rst           (rst),
      .i_frame_start (w_frame_start),
      .i_mode_fade   (i_mode_fade),
      .i_pwm_cnt     (r_pwm_cnt),
      .i_target      (r_palette[w_tgt_idx]),
      .o_rgb         (o_rgb_led[3*k +: 3])
    );
  end

  assign o_step_idx   = r_step_idx;
  assign o_step_pulse = r_step_pulse;

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Bench for rgb_pwm_sequencer: directed scenarios plus random traffic,
// every cycle compared against a frame/dwell arithmetic model.
module tb_rgb_pwm_sequencer;

  localparam int unsigned PB    = 4;
  localparam int unsigned PD    = 1;
  localparam int unsigned SC    = 64;
  localparam int unsigned NS    = 3;
  localparam int unsigned NL    = 2;
  localparam int unsigned FRAME = 1 << PB;
  localparam int unsigned IW    = $clog2(NS);
  localparam int unsigned DW    = 3 * PB;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          fade;
  logic          we;
  logic [IW-1:0] wa;
  logic [DW-1:0] wd;
  logic [IW-1:0] step_idx;
  logic          pulse;
  logic [3*NL-1:0] rgb;

  always #5 clk = ~clk;

  rgb_pwm_sequencer #(
    .PWM_BITS    (PB),
    .PWM_DIV     (PD),
    .STEP_CYCLES (SC),
    .NUM_STEPS   (NS),
    .NUM_LEDS    (NL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (en),
    .i_mode_fade  (fade),
    .i_wr_en      (we),
    .i_wr_addr    (wa),
    .i_wr_data    (wd),
    .o_step_idx   (step_idx),
    .o_step_pulse (pulse),
    .o_rgb_led    (rgb)
  );

  int total = 0;
  int bad   = 0;

  // Model: cycles since reset, count of enabled cycles, palette, duties.
  int          cyc;
  int          en_cnt;
  int          pal  [NS][3];
  int          duty [NL][3];
  logic [3*NL-1:0] exp_rgb;
  logic        exp_pulse;
  int          exp_step;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int toward(input int cur, input int tgt);
    if (cur < tgt) return cur + 1;
    if (cur > tgt) return cur - 1;
    return cur;
  endfunction

  task automatic model_reset();
    cyc       = 0;
    en_cnt    = 0;
    exp_rgb   = '0;
    exp_pulse = 1'b0;
    exp_step  = 0;
    for (int e = 0; e < NS; e++)
      for (int c = 0; c < 3; c++)
        pal[e][c] = (c == 2 - (e % 3)) ? FRAME - 1 : 0;
    for (int k = 0; k < NL; k++)
      for (int c = 0; c < 3; c++)
        duty[k][c] = 0;
  endtask

  // Advance the model over one clock edge using the inputs held across it.
  task automatic model_step();
    int pos;
    int sb;
    int tgt;
    bit frame;
    pos   = (cyc / PD) % FRAME;
    frame = ((cyc % PD) == PD - 1) && (pos == FRAME - 1);
    for (int k = 0; k < NL; k++)
      for (int c = 0; c < 3; c++)
        exp_rgb[3*k+c] = (pos < duty[k][c]);
    sb = (en_cnt / SC) % NS;
    if (frame)
      for (int k = 0; k < NL; k++)
        for (int c = 0; c < 3; c++) begin
          tgt = pal[(sb + k) % NS][c];
          duty[k][c] = fade ? toward(duty[k][c], tgt) : tgt;
        end
    if (we && int'(wa) < NS)
      for (int c = 0; c < 3; c++) pal[int'(wa)][c] = int'(wd[c*PB +: PB]);
    if (en) begin
      en_cnt++;
      exp_pulse = ((en_cnt % SC) == 0);
    end else begin
      exp_pulse = 1'b0;
    end
    exp_step = (en_cnt / SC) % NS;
    cyc++;
  endtask

  task automatic compare_all();
    check_eq("rgb_led", 32'(rgb), 32'(exp_rgb));
    check_eq("step_idx", 32'(step_idx), 32'(exp_step));
    check_eq("step_pulse", 32'(pulse), 32'(exp_pulse));
  endtask

  task automatic cycle_n(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      model_step();
      compare_all();
    end
  endtask

  task automatic write_entry(input logic [IW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1;
    wa = a;
    wd = d;
    cycle_n(1);
    we = 1'b0;
  endtask

  // Count high cycles of LED0 R/G/B and LED1 B over one frame.
  task automatic measure_frame(output int r0, output int g0, output int b0, output int b1);
    r0 = 0; g0 = 0; b0 = 0; b1 = 0;
    repeat (FRAME) begin
      cycle_n(1);
      if (rgb[2]) r0++;
      if (rgb[1]) g0++;
      if (rgb[0]) b0++;
      if (rgb[3]) b1++;
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_rgb_zero", 32'(rgb), 32'd0);
    check_eq("rst_step_zero", 32'(step_idx), 32'd0);
    check_eq("rst_pulse_zero", 32'(pulse), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int r0, g0, b0, b1;
    logic [3*NL-1:0] dark;
    rst = 1'b1; en = 1'b1; fade = 1'b0; we = 1'b0; wa = '0; wd = '0;
    repeat (3) @(negedge clk);
    model_reset();
    compare_all();
    rst = 1'b0;

    // Dark first frame, then full red on LED0.
    dark = '0;
    repeat (FRAME) begin
      cycle_n(1);
      dark |= rgb;
    end
    check_eq("dark_first_frame", 32'(dark), 32'd0);
    measure_frame(r0, g0, b0, b1);
    check_eq("step0_led0_r", 32'(r0), 32'd15);
    check_eq("step0_led0_g", 32'(g0), 32'd0);
    check_eq("step0_led1_b", 32'(b1), 32'd0);

    // Palette write during step 0, plus an ignored out-of-range write.
    write_entry(2'd1, {4'd4, 4'd8, 4'd0});
    write_entry(2'd3, 12'hFFF);
    cycle_n(30);
    check_eq("step_at_64", 32'(step_idx), 32'd1);
    check_eq("pulse_at_64", 32'(pulse), 32'd1);
    cycle_n(16);
    measure_frame(r0, g0, b0, b1);
    check_eq("step1_led0_r", 32'(r0), 32'd4);
    check_eq("step1_led0_g", 32'(g0), 32'd8);
    check_eq("step1_led0_b", 32'(b0), 32'd0);
    check_eq("step1_led1_b", 32'(b1), 32'd15);

    // Hold, then resume from the held dwell count.
    en = 1'b0;
    cycle_n(200);
    check_eq("hold_step", 32'(step_idx), 32'd1);
    en = 1'b1;
    cycle_n(100);

    // Fade red -> green after a mid-run reset.
    async_reset();
    cycle_n(20);
    fade = 1'b1;
    cycle_n(50);
    en = 1'b0;
    cycle_n(42);
    measure_frame(r0, g0, b0, b1);
    check_eq("fade_mid_r", 32'(r0), 32'd12);
    check_eq("fade_mid_g", 32'(g0), 32'd3);
    cycle_n(272);
    measure_frame(r0, g0, b0, b1);
    check_eq("fade_end_r", 32'(r0), 32'd0);
    check_eq("fade_end_g", 32'(g0), 32'd15);

    // Write to the entry being loaded on the frame_start edge.
    fade = 1'b0;
    cycle_n(15);
    write_entry(2'd1, {4'd2, 4'd0, 4'd0});
    measure_frame(r0, g0, b0, b1);
    check_eq("collide_old_g", 32'(g0), 32'd15);
    check_eq("collide_old_r", 32'(r0), 32'd0);
    measure_frame(r0, g0, b0, b1);
    check_eq("collide_new_r", 32'(r0), 32'd2);
    check_eq("collide_new_g", 32'(g0), 32'd0);

    // Random traffic.
    en = 1'b1;
    repeat (3000) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) fade = ~fade;
      we = ($urandom_range(0, 19) == 0);
      wa = IW'($urandom_range(0, 3));
      wd = DW'($urandom);
      cycle_n(1);
    end
    we = 1'b0;
    async_reset();
    cycle_n(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
